lru_grant_sequencer: RTL and testbench
======================================

Name: lru_grant_sequencer

Overview:
- Downstream consumer of the LRU arbiter's one-hot grant vector.
- Latches the winning client and drives the arbiter's gnt_busy while the client's burst runs.
- Sequences the burst as a valid/ready beat stream and pulses a completion strobe.
- Completion lets the arbiter update its LRU state and re-arbitrate.

Parameters:
- NUMCLIENTS, 4, number of requesters; matches arbiter gnt width.
- IDX_W, 2, width of the owner index; equals clog2(NUMCLIENTS).
- LEN_W, 4, per-client burst length field width; field value = beats-1.
- WDOG_CYCLES, 64, stall limit used only when WATCHDOG_EN is defined.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- gnt, input, NUMCLIENTS, grant vector from the arbiter; nominally one-hot.
- req_len, input, NUMCLIENTS*LEN_W, packed per-client burst length; client i occupies bits [i*LEN_W +: LEN_W].
- gnt_busy, output, 1, registered; to the arbiter; high while a burst is owned.
- owner_onehot, output, NUMCLIENTS, registered copy of the accepted grant.
- owner_idx, output, IDX_W, binary index of the owner.
- xfer_valid, output, 1, beat valid toward the datapath.
- xfer_ready, input, 1, datapath accepts the beat.
- xfer_last, output, 1, high with xfer_valid on the final beat.
- done, output, 1, one-cycle pulse; burst complete.
- err_multi, output, 1, one-cycle pulse; multi-hot gnt was sampled.

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; beat counter 0; latched length 0.
- FSM states:
  - IDLE: gnt_busy=0, xfer_valid=0.
    - Any gnt bit set on a rising edge: accept the grant.
    - Owner = lowest set index; latch owner_onehot, owner_idx, and len = req_len[owner].
    - Clear beat counter; go to XFER.
    - If more than one gnt bit was set, pulse err_multi in the next cycle.
  - XFER: gnt_busy=1, xfer_valid=1.
    - A beat completes when xfer_valid & xfer_ready; counter increments by 1.
    - xfer_last = (counter == len).
    - Handshake with xfer_last: go to DONE.
    - xfer_ready held low: stay in XFER indefinitely; counter holds (watchdog aside).
  - DONE: one cycle; done=1, gnt_busy=1, xfer_valid=0, owner outputs still valid.
    - Next state IDLE; owner_onehot and owner_idx clear on entry to IDLE.
- Latency (grant sampled at edge N):
  - gnt_busy and xfer_valid high from cycle N+1.
  - Single beat with ready=1: handshake in N+1, done in N+2, IDLE in N+3.
  - Earliest next acceptance is the edge ending N+3.
- gnt changes while not in IDLE: ignored; len is frozen at acceptance.
- len = 0 gives 1 beat; len = all-ones gives 2^LEN_W beats. The counter is LEN_W bits and never wraps within a burst.
- Reset mid-burst: immediate return to reset state; the burst is abandoned and no done pulse is issued.
- gnt_busy is purely a function of state: high in XFER and DONE only.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined:
  - A stall counter in XFER counts consecutive cycles with xfer_valid & !xfer_ready; it clears on any handshake.
  - On reaching WDOG_CYCLES: force DONE, pulse done plus an extra output timeout (1 bit, registered pulse) in the same cycle.
  - xfer_last is not asserted for that abort.
- Not defined: no timeout port, no stall counter; a stalled burst waits forever.

Decomposition:
- Shared package lru_arb_pkg:
  - NUMCLIENTS and IDX_W defaults.
  - FSM state enum {IDLE, XFER, DONE}.
  - Function for lowest-set-bit one-hot to index plus popcount>1 check; also used by the arbiter bench.
- Sub-module lru_onehot_enc: combinational priority encoder producing the one-hot owner, the binary index, and the multi-hot flag.
- FSM, counters and watchdog stay in the top.

Test Plan:
- Reset then gnt=4'b0100, req_len[2]=3, xfer_ready=1 -> owner_idx=2, gnt_busy high 5 cycles, 4 beats, xfer_last on 4th, done one cycle after the 4th beat.
- gnt=4'b0001, len=0, xfer_ready low 3 cycles then high -> xfer_valid held 4 cycles, single beat with xfer_last, done pulse, gnt_busy drops next cycle.
- gnt=4'b1010 -> owner_idx=1, err_multi pulses once, burst length from req_len[1].
- gnt toggled to 4'b1000 and req_len[1] changed mid-burst -> owner and beat count unchanged.
- rst asserted during beat 2 of a 4-beat burst -> all outputs 0 immediately, no done; a new gnt is then accepted normally.
- WATCHDOG_EN, WDOG_CYCLES=8, xfer_ready tied low -> done and timeout pulse together after 8 stalled cycles, xfer_last never asserted, gnt_busy drops next cycle.

Source files
------------

// File: rtl/lru_arb_pkg.sv
// ---------------------------------------------------------------------------
// lru_arb_pkg
// Shared definitions for the LRU arbiter and its grant sequencer:
//   - default client count and owner-index width
//   - sequencer FSM state encoding
//   - lowest-set-bit picker with multi-hot detection (reference helper,
//     usable by the arbiter side and its benches)
// No ports (package).
// ---------------------------------------------------------------------------
package lru_arb_pkg;

    localparam int LRU_NUMCLIENTS = 4;
    localparam int LRU_IDX_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } lru_seq_state_t;

    typedef struct packed {
        logic [LRU_IDX_W-1:0] idx;
        logic                 any;
        logic                 multi;
    } lru_pick_t;

    // Walks from the top bit down so the last hit is the lowest index.
    function automatic lru_pick_t lru_pick_lowest(input logic [LRU_NUMCLIENTS-1:0] vec);
        lru_pick_t p;
        int        cnt;
        p   = '0;
        cnt = 0;
        for (int i = LRU_NUMCLIENTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                p.idx = LRU_IDX_W'(i);
                cnt++;
            end
        end
        p.any   = (cnt != 0);
        p.multi = (cnt > 1);
        return p;
    endfunction

endpackage

// File: rtl/lru_onehot_enc.sv
// ---------------------------------------------------------------------------
// lru_onehot_enc
// Combinational lowest-index priority encoder for the arbiter grant vector.
// Ports:
//   i_vec     [N-1:0]   grant vector (nominally one-hot)
//   o_onehot  [N-1:0]   one-hot of the lowest set bit (0 when none)
//   o_idx     [IW-1:0]  binary index of the lowest set bit
//   o_any               at least one bit set
//   o_multi             more than one bit set
// ---------------------------------------------------------------------------
module lru_onehot_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_vec,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any,
    output logic          o_multi
);

    logic w_found;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_multi  = 1'b0;
        w_found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                if (!w_found) begin
                    o_onehot[i] = 1'b1;
                    o_idx       = IW'(i);
                    w_found     = 1'b1;
                end else begin
                    o_multi = 1'b1;
                end
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/lru_grant_sequencer.sv
// ---------------------------------------------------------------------------
// lru_grant_sequencer
// Accepts a grant from the LRU arbiter, holds gnt_busy while the owning
// client's burst runs as a valid/ready beat stream, then pulses done so the
// arbiter can update LRU state and re-arbitrate.
//
// Optional feature macro: WATCHDOG_EN
//   defined   -> stall counter aborts a burst after WDOG_CYCLES consecutive
//                stalled beats; adds the o_timeout pulse port.
//   undefined -> a stalled burst waits forever; no o_timeout port.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_gnt           grant vector from the arbiter
//   i_req_len       packed per-client length (beats-1), client i at [i*LEN_W +: LEN_W]
//   o_gnt_busy      high in XFER and DONE
//   o_owner_onehot  latched one-hot owner
//   o_owner_idx     latched binary owner index
//   o_xfer_valid    beat valid
//   i_xfer_ready    beat accepted by datapath
//   o_xfer_last     final beat marker (with o_xfer_valid)
//   o_done          one-cycle completion pulse
//   o_err_multi     one-cycle pulse: multi-hot grant was accepted
//   o_timeout       (WATCHDOG_EN only) one-cycle pulse with o_done on abort
//
// state | meaning
// IDLE  | waiting for any grant bit
// XFER  | burst in progress, xfer_valid high
// DONE  | one-cycle completion, done pulse, owner still valid
// ---------------------------------------------------------------------------
module lru_grant_sequencer
    import lru_arb_pkg::*;
#(
    parameter int NUMCLIENTS  = LRU_NUMCLIENTS,
    parameter int IDX_W       = LRU_IDX_W,
    parameter int LEN_W       = 4
`ifdef WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 64
`endif
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUMCLIENTS-1:0]       i_gnt,
    input  logic [NUMCLIENTS*LEN_W-1:0] i_req_len,
    output logic                        o_gnt_busy,
    output logic [NUMCLIENTS-1:0]       o_owner_onehot,
    output logic [IDX_W-1:0]            o_owner_idx,
    output logic                        o_xfer_valid,
    input  logic                        i_xfer_ready,
    output logic                        o_xfer_last,
    output logic                        o_done,
    output logic                        o_err_multi
`ifdef WATCHDOG_EN
    ,
    output logic                        o_timeout
`endif
);

    lru_seq_state_t          r_state;
    logic                    r_busy;
    logic                    r_valid;
    logic                    r_last;
    logic                    r_done;
    logic                    r_err;
    logic [NUMCLIENTS-1:0]   r_owner_oh;
    logic [IDX_W-1:0]        r_owner_idx;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_cnt;

    logic [NUMCLIENTS-1:0]   w_oh;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_any;
    logic                    w_multi;
    logic [LEN_W-1:0]        w_len;
    logic [LEN_W-1:0]        w_cnt_inc;

`ifdef WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0]       r_stall;
    logic                    r_timeout;
`endif

    lru_onehot_enc #(
        .N  (NUMCLIENTS),
        .IW (IDX_W)
    ) u_enc (
        .i_vec    (i_gnt),
        .o_onehot (w_oh),
        .o_idx    (w_idx),
        .o_any    (w_any),
        .o_multi  (w_multi)
    );

    assign w_len     = i_req_len[w_idx*LEN_W +: LEN_W];
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_owner_oh  <= '0;
            r_owner_idx <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
`ifdef WATCHDOG_EN
            r_stall     <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
`ifdef WATCHDOG_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= XFER;
                        r_busy      <= 1'b1;
                        r_valid     <= 1'b1;
                        r_owner_oh  <= w_oh;
                        r_owner_idx <= w_idx;
                        r_len       <= w_len;
                        r_cnt       <= '0;
                        // A zero length field is a single-beat burst, so the
                        // first beat is already the last one.
                        r_last      <= (w_len == '0);
                        r_err       <= w_multi;
`ifdef WATCHDOG_EN
                        r_stall     <= '0;
`endif
                    end
                end
                XFER: begin
                    if (i_xfer_ready) begin
                        if (r_last) begin
                            // Counter is left as-is so it never wraps on a
                            // full 2^LEN_W burst.
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_last <= (w_cnt_inc == r_len);
                        end
`ifdef WATCHDOG_EN
                        r_stall <= '0;
`endif
                    end
`ifdef WATCHDOG_EN
                    else if (r_stall == WDOG_W'(WDOG_CYCLES - 1)) begin
                        // Abort: this edge ends the WDOG_CYCLES-th stalled cycle.
                        r_state   <= DONE;
                        r_valid   <= 1'b0;
                        r_last    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_stall   <= '0;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_owner_oh  <= '0;
                    r_owner_idx <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt_busy     = r_busy;
    assign o_owner_onehot = r_owner_oh;
    assign o_owner_idx    = r_owner_idx;
    assign o_xfer_valid   = r_valid;
    assign o_xfer_last    = r_last;
    assign o_done         = r_done;
    assign o_err_multi    = r_err;
`ifdef WATCHDOG_EN
    assign o_timeout      = r_timeout;
`endif

endmodule

// File: tb/tb_lru_grant_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lru_grant_sequencer
// Directed stimulus pushes hand-computed expected events (err, beat, done)
// into a queue; a monitor pops and compares whenever the DUT presents one.
// ---------------------------------------------------------------------------
module tb_lru_grant_sequencer;

    localparam int K_ERR  = 0;
    localparam int K_BEAT = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int kind;
        int idx;
        int last;
        int tmo;
    } exp_t;

    exp_t q[$];

    logic        clk;
    logic        rst;
    logic [3:0]  gnt;
    logic [15:0] req_len;
    logic        xfer_ready;
    logic        gnt_busy;
    logic [3:0]  owner_onehot;
    logic [1:0]  owner_idx;
    logic        xfer_valid;
    logic        xfer_last;
    logic        done;
    logic        err_multi;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef WATCHDOG_EN
    lru_grant_sequencer #(.WDOG_CYCLES(8)) dut (
`else
    lru_grant_sequencer dut (
`endif
        .i_clk          (clk),
        .i_rst          (rst),
        .i_gnt          (gnt),
        .i_req_len      (req_len),
        .o_gnt_busy     (gnt_busy),
        .o_owner_onehot (owner_onehot),
        .o_owner_idx    (owner_idx),
        .o_xfer_valid   (xfer_valid),
        .i_xfer_ready   (xfer_ready),
        .o_xfer_last    (xfer_last),
        .o_done         (done),
        .o_err_multi    (err_multi)
`ifdef WATCHDOG_EN
        ,
        .o_timeout      (timeout)
`endif
    );

`ifndef WATCHDOG_EN
    assign timeout = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int idx, input int last, input int tmo);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.last = last;
        e.tmo  = tmo;
        q.push_back(e);
    endtask

    task automatic push_burst(input int idx, input int nbeats);
        for (int b = 0; b < nbeats; b++) push(K_BEAT, idx, (b == nbeats - 1) ? 1 : 0, 0);
        push(K_DONE, idx, 0, 0);
    endtask

    task automatic pop_cmp(input int kind, input int idx, input int last, input int tmo);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got event kind %0d idx %0d with queue empty at %0t",
                     kind, idx, $time);
        end else begin
            e = q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_idx", idx, e.idx);
            if (e.kind == K_BEAT) chk("sb_last", last, e.last);
            if (e.kind == K_DONE) chk("sb_timeout", tmo, e.tmo);
        end
    endtask

    // Monitor: sample away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err_multi) pop_cmp(K_ERR, int'(owner_idx), 0, 0);
                if (xfer_valid && xfer_ready) pop_cmp(K_BEAT, int'(owner_idx), int'(xfer_last), 0);
                if (done) pop_cmp(K_DONE, int'(owner_idx), 0, int'(timeout));
            end
        end
    end

    // Presents v for exactly one rising edge; returns at #1 after the accept edge.
    task automatic accept(input logic [3:0] v);
        @(posedge clk); #1;
        gnt = v;
        @(posedge clk); #1;
        gnt = 4'b0000;
    endtask

    // Counts busy cycles until busy falls; bounded so a stuck DUT cannot hang.
    task automatic count_busy(input string name, input int exp);
        int n;
        bit ended;
        n = 0;
        ended = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (gnt_busy) n++;
            else if (n > 0) begin
                ended = 1;
                break;
            end
        end
        if (!ended) chk({name, "_bound"}, 0, 1);
        chk(name, n, exp);
        chk({name, "_owner_clr"}, int'(owner_onehot), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, int'(gnt_busy), 0);
        chk({name, "_oh"}, int'(owner_onehot), 0);
        chk({name, "_idx"}, int'(owner_idx), 0);
        chk({name, "_valid"}, int'(xfer_valid), 0);
        chk({name, "_last"}, int'(xfer_last), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_err"}, int'(err_multi), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst        = 1'b1;
        gnt        = 4'b0000;
        req_len    = 16'h0;
        xfer_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // 1: client 2, len 3 -> 4 beats, busy 5 cycles
        req_len[2*4 +: 4] = 4'd3;
        req_len[1*4 +: 4] = 4'd2;
        req_len[0*4 +: 4] = 4'd0;
        xfer_ready = 1'b1;
        push_burst(2, 4);
        accept(4'b0100);
        chk("t1_owner_oh", int'(owner_onehot), 4'b0100);
        chk("t1_owner_idx", int'(owner_idx), 2);
        count_busy("t1_busy_cycles", 5);

        // 2: client 0, len 0, ready low 3 cycles
        xfer_ready = 1'b0;
        push_burst(0, 1);
        accept(4'b0001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_valid_stalled", int'(xfer_valid), 1);
            chk("t2_last_stalled", int'(xfer_last), 1);
            @(posedge clk); #1;
        end
        xfer_ready = 1'b1;
        @(negedge clk);
        chk("t2_valid_hs", int'(xfer_valid), 1);
        @(negedge clk);
        chk("t2_done_busy", int'(gnt_busy), 1);
        chk("t2_done_valid", int'(xfer_valid), 0);
        chk("t2_done", int'(done), 1);
        @(negedge clk);
        chk("t2_busy_drop", int'(gnt_busy), 0);

        // 3: multi-hot 1010 -> owner 1, err pulse, 3 beats from req_len[1]=2
        push(K_ERR, 1, 0, 0);
        push_burst(1, 3);
        accept(4'b1010);
        chk("t3_owner_oh", int'(owner_onehot), 4'b0010);
        count_busy("t3_busy_cycles", 4);

        // 4: gnt and req_len[1] disturbed mid-burst -> ignored
        push_burst(1, 3);
        accept(4'b0010);
        gnt = 4'b1000;
        req_len[1*4 +: 4] = 4'd7;
        @(posedge clk); #1;
        gnt = 4'b0000;
        chk("t4_owner_idx", int'(owner_idx), 1);
        count_busy("t4_busy_cycles", 3);
        req_len[1*4 +: 4] = 4'd2;

        // 5: reset during beat 2 of a 4-beat burst, then a fresh grant
        push(K_BEAT, 2, 0, 0);
        accept(4'b0100);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_all_zero("t5_mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        push_burst(0, 1);
        accept(4'b0001);
        count_busy("t5_after_reset_busy", 2);

        // 6: len all-ones -> 16 beats
        req_len[3*4 +: 4] = 4'hF;
        push_burst(3, 16);
        accept(4'b1000);
        count_busy("t6_busy_cycles", 17);

`ifdef WATCHDOG_EN
        // 7: watchdog abort after 8 stalled cycles
        xfer_ready = 1'b0;
        push(K_DONE, 2, 0, 1);
        accept(4'b0100);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t7_last_low", int'(xfer_last), 0);
            chk("t7_no_done", int'(done), 0);
        end
        @(negedge clk);
        chk("t7_done", int'(done), 1);
        chk("t7_timeout", int'(timeout), 1);
        chk("t7_busy", int'(gnt_busy), 1);
        @(negedge clk);
        chk("t7_busy_drop", int'(gnt_busy), 0);
        xfer_ready = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("sb_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
